// File: rtl/c3lib_rstseq_pkg.sv
// Shared types and helpers for the reset sequencer.
//   rstseq_state_e : sequencer FSM state encoding
//   tmo_width()    : bits needed to count 0 .. cycles-1 ack-wait cycles
package c3lib_rstseq_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDelay   = 3'd1,
    StWaitAck = 3'd2,
    StDone    = 3'd3,
    StErr     = 3'd4
  } rstseq_state_e;

  function automatic int unsigned tmo_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/c3lib_rstseq_cnt.sv
// Loadable down-counter used for the pre-release delay of each stage.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (counter clears to 0)
//   load     : load load_val on the next edge (takes priority over counting)
//   load_val : value to load
//   zero     : counter currently holds 0
// The counter decrements every cycle while nonzero, so after a load of N it
// reads 0 exactly N edges later.
module c3lib_rstseq_cnt #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 zero
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntOne;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/c3lib_rstseq_ctrl.sv
// Ordered reset-release sequencer for NUM_STAGES reset domains.
//   clk             : clock
//   rst_n           : asynchronous active-low reset
//   seq_start       : level request; high releases domains in order, low holds all in reset
//   dly_cfg         : per-stage pre-release delay in cycles (sampled at counter load)
//   stage_ack       : per-domain "out of reset" acknowledge
//   stage_rst_n_out : registered active-low reset per domain, thermometer-coded from bit 0
//   seq_busy        : sequence in progress (delaying or waiting for ack)
//   seq_done        : all domains released and acknowledged
//   seq_err         : ack timeout; all domains held in reset until seq_start drops
module c3lib_rstseq_ctrl
  import c3lib_rstseq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned TMO_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seq_start,
  input  logic [CNT_WIDTH-1:0]  dly_cfg,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n_out,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  seq_err
);

  localparam int unsigned IdxW = $clog2(NUM_STAGES);
  localparam int unsigned TmoW = tmo_width(TMO_CYCLES);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_STAGES - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);

  rstseq_state_e         state_q;
  logic [IdxW-1:0]       idx_q;
  logic [TmoW-1:0]       tmo_q;
  logic [NUM_STAGES-1:0] stage_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic cnt_load;
  logic cnt_zero;
  logic cur_ack;

  assign cur_ack = stage_ack[idx_q];

  // Reload the delay whenever a new stage enters DELAY.
  assign cnt_load = seq_start &&
                    ((state_q == StIdle) || ((state_q == StWaitAck) && cur_ack));

  c3lib_rstseq_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_dly_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (dly_cfg),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tmo_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (!seq_start) begin
      // Abort overrides every other transition.
      state_q <= StIdle;
      idx_q   <= '0;
      tmo_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StDelay;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
        StDelay: begin
          if (cnt_zero) begin
            stage_q[idx_q] <= 1'b1;
            tmo_q          <= '0;
            state_q        <= StWaitAck;
          end
        end
        StWaitAck: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (cur_ack) begin
            if (idx_q == IdxLast) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + IdxOne;
              state_q <= StDelay;
            end
          end else if (tmo_q == TmoLast) begin
            state_q <= StErr;
            stage_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TmoOne;
          end
        end
        StDone: begin
        end
        StErr: begin
        end
        default: begin
          state_q <= StIdle;
          stage_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stage_rst_n_out = stage_q;
  assign seq_busy        = busy_q;
  assign seq_done        = done_q;
  assign seq_err         = err_q;

endmodule

// File: tb/tb_c3lib_rstseq_ctrl.sv
// Self-checking bench for c3lib_rstseq_ctrl. Expected release/clear edges of
// stage_rst_n_out (cycle number and value) are queued as each scenario is
// driven; a monitor queues the observed edges and each scenario compares them.
module tb_c3lib_rstseq_ctrl;

  localparam int NS  = 4;
  localparam int CW  = 8;
  localparam int TMO = 8;

  logic          clk;
  logic          rst_n;
  logic          seq_start;
  logic [CW-1:0] dly_cfg;
  logic [NS-1:0] stage_ack;
  logic [NS-1:0] stage_rst_n_out;
  logic          seq_busy;
  logic          seq_done;
  logic          seq_err;

  typedef struct {
    int          cyc;
    logic [NS-1:0] val;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t mon_ev;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int ack_mode = 0;  // 0: no ack, 1: pulse 2 cycles after release, 2: tied, 3: manual

  logic [NS-1:0] last_val = '0;
  logic [NS-1:0] h1 = '0;
  logic [NS-1:0] h2 = '0;

  c3lib_rstseq_ctrl #(
    .NUM_STAGES (NS),
    .CNT_WIDTH  (CW),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .seq_start       (seq_start),
    .dly_cfg         (dly_cfg),
    .stage_ack       (stage_ack),
    .stage_rst_n_out (stage_rst_n_out),
    .seq_busy        (seq_busy),
    .seq_done        (seq_done),
    .seq_err         (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge monitor and automatic ack responder, both on the inactive edge.
  always @(negedge clk) begin
    if (stage_rst_n_out !== last_val) begin
      mon_ev.cyc = cyc;
      mon_ev.val = stage_rst_n_out;
      obs_q.push_back(mon_ev);
      last_val = stage_rst_n_out;
    end
    case (ack_mode)
      0: stage_ack = '0;
      1: stage_ack = stage_rst_n_out & h1 & ~h2;
      2: stage_ack = stage_rst_n_out;
      default: ;
    endcase
    h2 = h1;
    h1 = stage_rst_n_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  task automatic push_exp(input int c, input logic [NS-1:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic settle();
    seq_start = 1'b0;
    ack_mode  = 0;
    repeat (3) @(negedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    seq_start = 1'b0;
    dly_cfg   = '0;
    stage_ack = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (stage_rst_n_out !== 4'b0000 || seq_busy !== 1'b0 || seq_done !== 1'b0 ||
        seq_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got rst=%b busy=%b done=%b err=%b, required 0000 0 0 0",
               stage_rst_n_out, seq_busy, seq_done, seq_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (stage_rst_n_out !== 4'b0000 || seq_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got rst=%b busy=%b, required 0000 0", stage_rst_n_out,
               seq_busy);
    end
  endtask

  task automatic test_nominal();
    int  t0;
    int  done_cyc;
    ev_t e;
    ev_t o;
    settle();
    ack_mode = 1;
    dly_cfg  = 8'd3;
    @(negedge clk);
    seq_start = 1'b1;
    t0 = cyc + 1;
    push_exp(t0 + 4,  4'b0001);
    push_exp(t0 + 10, 4'b0011);
    push_exp(t0 + 16, 4'b0111);
    push_exp(t0 + 22, 4'b1111);
    @(negedge clk);
    checks++;
    if (seq_busy !== 1'b1 || seq_done !== 1'b0) begin
      failures++;
      $display("FAIL nominal_busy: got busy=%b done=%b, required 1 0", seq_busy, seq_done);
    end
    for (int i = 0; i < 60; i++) begin
      if (seq_done === 1'b1) break;
      @(negedge clk);
    end
    done_cyc = cyc;
    checks++;
    if (seq_done !== 1'b1 || done_cyc != t0 + 24) begin
      failures++;
      $display("FAIL nominal_done: got done=%b at cyc %0d, required 1 at cyc %0d", seq_done,
               done_cyc, t0 + 24);
    end
    checks++;
    if (seq_busy !== 1'b0 || seq_err !== 1'b0 || stage_rst_n_out !== 4'b1111) begin
      failures++;
      $display("FAIL nominal_flags: got busy=%b err=%b rst=%b, required 0 0 1111", seq_busy,
               seq_err, stage_rst_n_out);
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL nominal_rel: got no edge, required cyc=%0d val=%b", e.cyc, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.val !== e.val) begin
          failures++;
          $display("FAIL nominal_rel: got cyc=%0d val=%b, required cyc=%0d val=%b", o.cyc,
                   o.val, e.cyc, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL nominal_extra: got %0d extra edges, required 0", obs_q.size());
    end
    seq_start = 1'b0;
    @(negedge clk);
    checks++;
    if (stage_rst_n_out !== 4'b0000 || seq_done !== 1'b0 || seq_busy !== 1'b0) begin
      failures++;
      $display("FAIL nominal_drop: got rst=%b done=%b busy=%b, required 0000 0 0",
               stage_rst_n_out, seq_done, seq_busy);
    end
  endtask

  task automatic test_zero_delay();
    int  t0;
    ev_t e;
    ev_t o;
    settle();
    ack_mode = 2;
    dly_cfg  = 8'd0;
    @(negedge clk);
    seq_start = 1'b1;
    t0 = cyc + 1;
    push_exp(t0 + 1, 4'b0001);
    push_exp(t0 + 3, 4'b0011);
    push_exp(t0 + 5, 4'b0111);
    push_exp(t0 + 7, 4'b1111);
    goto(t0 + 7);
    checks++;
    if (seq_done !== 1'b0 || seq_busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_predone: got done=%b busy=%b, required 0 1", seq_done, seq_busy);
    end
    goto(t0 + 8);
    checks++;
    if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: got done=%b busy=%b, required 1 0", seq_done, seq_busy);
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL zero_rel: got no edge, required cyc=%0d val=%b", e.cyc, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.val !== e.val) begin
          failures++;
          $display("FAIL zero_rel: got cyc=%0d val=%b, required cyc=%0d val=%b", o.cyc, o.val,
                   e.cyc, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL zero_extra: got %0d extra edges, required 0", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    int  t0;
    ev_t e;
    ev_t o;
    settle();
    ack_mode  = 3;
    stage_ack = 4'b1101;  // every ack except the one stage 1 needs
    dly_cfg   = 8'd1;
    @(negedge clk);
    seq_start = 1'b1;
    t0 = cyc + 1;
    push_exp(t0 + 2,  4'b0001);
    push_exp(t0 + 5,  4'b0011);
    push_exp(t0 + 13, 4'b0000);
    goto(t0 + 12);
    checks++;
    if (seq_err !== 1'b0 || seq_busy !== 1'b1) begin
      failures++;
      $display("FAIL tmo_early: got err=%b busy=%b, required 0 1", seq_err, seq_busy);
    end
    goto(t0 + 13);
    checks++;
    if (seq_err !== 1'b1 || seq_busy !== 1'b0 || seq_done !== 1'b0 ||
        stage_rst_n_out !== 4'b0000) begin
      failures++;
      $display("FAIL tmo_err: got err=%b busy=%b done=%b rst=%b, required 1 0 0 0000", seq_err,
               seq_busy, seq_done, stage_rst_n_out);
    end
    goto(t0 + 16);
    checks++;
    if (seq_err !== 1'b1 || stage_rst_n_out !== 4'b0000) begin
      failures++;
      $display("FAIL tmo_hold: got err=%b rst=%b, required 1 0000", seq_err, stage_rst_n_out);
    end
    seq_start = 1'b0;
    @(negedge clk);
    checks++;
    if (seq_err !== 1'b0 || seq_busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear: got err=%b busy=%b, required 0 0", seq_err, seq_busy);
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL tmo_rel: got no edge, required cyc=%0d val=%b", e.cyc, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.val !== e.val) begin
          failures++;
          $display("FAIL tmo_rel: got cyc=%0d val=%b, required cyc=%0d val=%b", o.cyc, o.val,
                   e.cyc, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL tmo_extra: got %0d extra edges, required 0", obs_q.size());
    end
  endtask

  task automatic test_abort();
    int  t0;
    int  t1;
    ev_t e;
    ev_t o;
    settle();
    ack_mode = 1;
    dly_cfg  = 8'd2;
    @(negedge clk);
    seq_start = 1'b1;
    t0 = cyc + 1;
    push_exp(t0 + 3,  4'b0001);
    push_exp(t0 + 8,  4'b0011);
    push_exp(t0 + 12, 4'b0000);
    goto(t0 + 11);
    seq_start = 1'b0;  // stage 2 is mid-delay here
    goto(t0 + 12);
    checks++;
    if (stage_rst_n_out !== 4'b0000 || seq_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear: got rst=%b busy=%b, required 0000 0", stage_rst_n_out,
               seq_busy);
    end
    goto(t0 + 13);
    seq_start = 1'b1;
    t1 = cyc + 1;
    push_exp(t1 + 3, 4'b0001);
    goto(t1 + 1);
    dly_cfg = 8'd50;  // must not affect the delay already loaded
    goto(t1 + 4);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL abort_rel: got no edge, required cyc=%0d val=%b", e.cyc, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.val !== e.val) begin
          failures++;
          $display("FAIL abort_rel: got cyc=%0d val=%b, required cyc=%0d val=%b", o.cyc, o.val,
                   e.cyc, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL abort_extra: got %0d extra edges, required 0", obs_q.size());
    end
  endtask

  task automatic test_coincide();
    int  t0;
    ev_t e;
    ev_t o;
    settle();
    ack_mode  = 3;
    stage_ack = '0;
    dly_cfg   = 8'd0;
    @(negedge clk);
    seq_start = 1'b1;
    t0 = cyc + 1;
    push_exp(t0 + 1,  4'b0001);
    push_exp(t0 + 10, 4'b0011);
    goto(t0 + 8);
    stage_ack = 4'b0001;  // sampled on the last allowed wait cycle
    goto(t0 + 9);
    stage_ack = '0;
    checks++;
    if (seq_err !== 1'b0 || seq_busy !== 1'b1) begin
      failures++;
      $display("FAIL coin_noerr: got err=%b busy=%b, required 0 1", seq_err, seq_busy);
    end
    goto(t0 + 10);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL coin_rel: got no edge, required cyc=%0d val=%b", e.cyc, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.val !== e.val) begin
          failures++;
          $display("FAIL coin_rel: got cyc=%0d val=%b, required cyc=%0d val=%b", o.cyc, o.val,
                   e.cyc, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL coin_extra: got %0d extra edges, required 0", obs_q.size());
    end
  endtask

  task automatic test_async_reset();
    int  t0;
    ev_t e;
    ev_t o;
    settle();
    ack_mode  = 3;
    stage_ack = '0;
    dly_cfg   = 8'd0;
    @(negedge clk);
    seq_start = 1'b1;
    t0 = cyc + 1;
    push_exp(t0 + 1, 4'b0001);
    push_exp(t0 + 4, 4'b0000);
    push_exp(t0 + 5, 4'b0001);
    goto(t0 + 3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stage_rst_n_out !== 4'b0000 || seq_busy !== 1'b0 || seq_done !== 1'b0 ||
        seq_err !== 1'b0) begin
      failures++;
      $display("FAIL arst_now: got rst=%b busy=%b done=%b err=%b, required 0000 0 0 0",
               stage_rst_n_out, seq_busy, seq_done, seq_err);
    end
    #1;
    rst_n = 1'b1;
    goto(t0 + 4);
    checks++;
    if (stage_rst_n_out !== 4'b0000 || seq_busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_restart: got rst=%b busy=%b, required 0000 1", stage_rst_n_out,
               seq_busy);
    end
    goto(t0 + 5);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL arst_rel: got no edge, required cyc=%0d val=%b", e.cyc, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.val !== e.val) begin
          failures++;
          $display("FAIL arst_rel: got cyc=%0d val=%b, required cyc=%0d val=%b", o.cyc, o.val,
                   e.cyc, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL arst_extra: got %0d extra edges, required 0", obs_q.size());
    end
  endtask

  task automatic test_max_delay();
    int  t0;
    ev_t e;
    ev_t o;
    settle();
    ack_mode = 2;
    dly_cfg  = 8'd255;
    @(negedge clk);
    seq_start = 1'b1;
    t0 = cyc + 1;
    push_exp(t0 + 256, 4'b0001);
    goto(t0 + 257);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL maxdly_rel: got no edge, required cyc=%0d val=%b", e.cyc, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || o.val !== e.val) begin
          failures++;
          $display("FAIL maxdly_rel: got cyc=%0d val=%b, required cyc=%0d val=%b", o.cyc,
                   o.val, e.cyc, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL maxdly_extra: got %0d extra edges, required 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_delay();
    test_timeout();
    test_abort();
    test_coincide();
    test_async_reset();
    test_max_delay();
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c3lib_rstseq_ctrl.md
C3LIB_RSTSEQ_CTRL -- requirements
Module: c3lib_rstseq_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_STAGES, default 4, meaning the number of sequenced reset domains (legal range 2..16).
REQ-002 The module SHALL have parameter CNT_WIDTH, default 8, meaning the width of the inter-stage delay counter.
REQ-003 The module SHALL have parameter TMO_CYCLES, default 1024, meaning the number of ack-wait cycles before timeout (legal range 1..65535).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port seq_start, input, 1 bit: level request; high = release domains in order, low = hold all domains in reset.
REQ-007 The module SHALL have port dly_cfg, input, CNT_WIDTH bits: pre-release delay per stage, in cycles.
REQ-008 The module SHALL have port stage_ack, input, NUM_STAGES bits: per-domain "out of reset" acknowledge, synchronous to clk.
REQ-009 The module SHALL have port stage_rst_n_out, output, NUM_STAGES bits: registered active-low reset per domain.
REQ-010 The module SHALL have port seq_busy, output, 1 bit: high in states DELAY and WAIT_ACK.
REQ-011 The module SHALL have port seq_done, output, 1 bit: high in state DONE.
REQ-012 The module SHALL have port seq_err, output, 1 bit: high in state ERR.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, DELAY, WAIT_ACK, DONE and ERR, with a stage index idx (0..NUM_STAGES-1).
REQ-014 IDLE with seq_start=1 sampled at edge T0 SHALL transition to DELAY, set idx=0 and load the delay counter with dly_cfg.
REQ-015 In DELAY, when the counter is nonzero, the counter SHALL decrement; when it is 0, stage_rst_n_out[idx] SHALL go to 1 and the FSM SHALL enter WAIT_ACK on the same edge.
REQ-016 Stage 0 SHALL be released at edge T0+dly_cfg+1 (dly_cfg=0 gives T0+1; dly_cfg=255 gives T0+256).
REQ-017 In WAIT_ACK, stage_ack[idx]=1 SHALL advance the FSM: if idx<NUM_STAGES-1, increment idx, reload the counter from dly_cfg and enter DELAY; otherwise enter DONE.
REQ-018 In WAIT_ACK, the timeout counter SHALL clear on entry and increment each cycle; after TMO_CYCLES cycles without ack the FSM SHALL enter ERR.
REQ-019 When ack and timeout expiry coincide in the same cycle, the ack SHALL win.
REQ-020 Only stage_ack[idx] SHALL be observed; the other ack bits SHALL be ignored.
REQ-021 dly_cfg SHALL be sampled only at counter load; changes mid-DELAY SHALL have no effect until the next load.
REQ-022 Released stages SHALL remain released (1) while the sequence continues; stage_rst_n_out SHALL be thermometer-coded from bit 0 at all times.
REQ-023 In ERR, all stage_rst_n_out bits SHALL be 0; the FSM SHALL leave ERR only on seq_start=0, going to IDLE.
REQ-024 seq_start=0 in any state SHALL force IDLE and all stage_rst_n_out=0 on the next edge, clearing seq_done and seq_busy (abort takes priority over all other transitions).
REQ-025 DONE SHALL hold all stage_rst_n_out=1 until seq_start=0.
REQ-026 seq_busy, seq_done and seq_err SHALL be registered and mutually exclusive.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, idx=0, both counters to 0, stage_rst_n_out all 0, and seq_busy, seq_done and seq_err to 0.
REQ-028 After rst_n deasserts, the first transition SHALL occur no earlier than the first rising clk edge with rst_n=1.
REQ-029 rst_n asserted mid-sequence SHALL behave identically to REQ-027, with no partial release retained.

Structure
REQ-030 Package c3lib_rstseq_pkg SHALL hold the state enum (rstseq_state_e) and the TMO counter width function/constant.
REQ-031 The loadable down-counter SHALL be a sub-module c3lib_rstseq_cnt, with ports clk, rst_n, load, load_val, and zero.
REQ-032 The FSM, idx and timeout logic SHALL reside in the top module.

Verification
REQ-033 Nominal: NUM_STAGES=4, dly_cfg=3, with each ack given 2 cycles after its release -> releases at T0+4, +10, +16, +22 and seq_done high 1 cycle after the ack for stage 3.
REQ-034 Zero delay: dly_cfg=0 with acks tied to stage_rst_n_out -> each stage releases 1 cycle after the previous stage's ack is sampled.
REQ-035 Timeout: TMO_CYCLES=8 with no ack for stage 1 -> seq_err high after 8 WAIT_ACK cycles and all outputs 0; dropping seq_start -> IDLE, seq_err=0.
REQ-036 Abort: seq_start=0 during stage 2 DELAY -> stage_rst_n_out=0000 on the next edge; restart begins again from stage 0.
REQ-037 Coincidence: ack on the exact timeout cycle -> no ERR, and the sequence advances.
REQ-038 Async reset: rst_n pulsed low mid-WAIT_ACK between clock edges -> outputs 0 immediately, and the FSM is in IDLE.
